// File: rtl/fp_addsub_hold_array_pkg.sv
// Shared constants for the floating-point add/sub hold array: default fpadd
// depth, common float encodings and the control FSM state encodings.
package fp_addsub_hold_array_pkg;

   localparam int          FPADD_LAT_DEFAULT = 4;
   localparam int          FP_WIDTH          = 32;

   localparam logic [31:0] FP_ONE            = 32'h3F80_0000;
   localparam logic [31:0] FP_ZERO           = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN           = 32'h7FC0_0000;

   // Control FSM encodings
   localparam logic [1:0]  ST_IDLE           = 2'd0;
   localparam logic [1:0]  ST_RUN            = 2'd1;
   localparam logic [1:0]  ST_ACC_WAIT       = 2'd2;

endpackage

// File: rtl/fp_addsub_hold_array_lane.sv
// One lane: fpadd instance, valid shift register matched to its depth, the
// held result register and the bypass mux that shows a fresh result at once.
module fp_lane_hold
   import fp_addsub_hold_array_pkg::*;
#(
   parameter int WIDTH     = FP_WIDTH,
   parameter int FPADD_LAT = FPADD_LAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             flush,
   input  logic             idle,
   input  logic             vin,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   output logic [WIDTH-1:0] held_out,
   output logic             busy
);

   logic [FPADD_LAT-1:0] vpipe;
   logic [FPADD_LAT-1:0] vnext;
   logic [WIDTH-1:0]     fp_y;
   logic [WIDTH-1:0]     held;

   fpadd #(.LAT(FPADD_LAT)) u_fpadd (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .op    (op),
      .a     (a),
      .b     (b),
      .y     (fp_y)
   );

   // Next valid-pipe contents: shift up one stage, new beat enters at bit 0
   always_comb begin
      vnext    = vpipe << 1;
      vnext[0] = vin;
   end

   // Valid pipe advances with ce; a flush kills everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     vpipe <= '0;
      else if (ce)    vpipe <= flush ? '0 : vnext;
   end

   assign res_valid = vpipe[FPADD_LAT-1];
   assign busy      = |vpipe;

   // Capture an emerging result; otherwise clear while idle (capture wins)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held <= FP_ZERO;
      end else if (ce) begin
         if (res_valid) held <= fp_y;
         else if (idle) held <= FP_ZERO;
      end
   end

   assign held_out = res_valid ? fp_y : held;

endmodule

// File: rtl/fpadd.sv
// Single-precision adder/subtractor, y = a op b, with a LAT-deep ce-enabled
// output pipeline. Denormal inputs and results are flushed to zero, rounding
// is round-to-nearest-even, exact cancellation gives +0.
module fpadd
   import fp_addsub_hold_array_pkg::*;
#(
   parameter int LAT = FPADD_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic        a_sgn, b_sgn, big_sgn;
   logic [7:0]  a_exp, b_exp, big_exp, sml_exp, sh;
   logic [26:0] a_man, b_man, big_man, sml_man, aligned, sticky_mask, norm;
   logic [27:0] sum;
   logic [9:0]  exp_n, exp_r;
   logic [4:0]  lz;
   logic        found, swap, up;
   logic [24:0] rnd;
   logic        a_inf, b_inf, a_nan, b_nan;
   logic [31:0] result;
   logic [31:0] pipe [LAT];

   // Unpack, align, add/subtract, normalise and round in one combinational pass
   always_comb begin
      a_sgn       = a[31];
      b_sgn       = b[31] ^ op;
      a_exp       = a[30:23];
      b_exp       = b[30:23];
      a_man       = (a_exp == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
      b_man       = (b_exp == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};
      a_inf       = (a_exp == 8'hFF) && (a[22:0] == 23'd0);
      b_inf       = (b_exp == 8'hFF) && (b[22:0] == 23'd0);
      a_nan       = (a_exp == 8'hFF) && (a[22:0] != 23'd0);
      b_nan       = (b_exp == 8'hFF) && (b[22:0] != 23'd0);

      // larger magnitude always goes first so the subtraction never wraps
      swap        = {b_exp, b[22:0]} > {a_exp, a[22:0]};
      big_sgn     = swap ? b_sgn : a_sgn;
      big_exp     = swap ? b_exp : a_exp;
      big_man     = swap ? b_man : a_man;
      sml_exp     = swap ? a_exp : b_exp;
      sml_man     = swap ? a_man : b_man;
      sh          = big_exp - sml_exp;

      sticky_mask = 27'd0;
      if (sh >= 8'd27) begin
         aligned = {26'd0, |sml_man};
      end else begin
         aligned     = sml_man >> sh;
         sticky_mask = (27'd1 << sh) - 27'd1;
         aligned[0]  = aligned[0] | (|(sml_man & sticky_mask));
      end

      lz    = 5'd0;
      found = 1'b0;
      if (big_sgn == (swap ? a_sgn : b_sgn)) begin
         sum = {1'b0, big_man} + {1'b0, aligned};
         if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, big_exp} + 10'd1;
         end else begin
            norm  = sum[26:0];
            exp_n = {2'b00, big_exp};
         end
      end else begin
         sum = {1'b0, big_man} - {1'b0, aligned};
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz    = lz + 5'd1;
            end
         end
         norm  = sum[26:0] << lz;
         exp_n = {2'b00, big_exp} - {5'd0, lz};
      end

      // round to nearest, ties to even; a carry out bumps the exponent
      up    = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd   = {1'b0, norm[26:3]} + {24'd0, up};
      exp_r = exp_n + {9'd0, rnd[24]};

      if (norm == 27'd0 || exp_n[9] || exp_n == 10'd0)
         result = FP_ZERO;
      else if (exp_r >= 10'd255)
         result = {big_sgn, 8'hFF, 23'd0};
      else
         result = {big_sgn, exp_r[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};

      if (a_nan || b_nan || (a_inf && b_inf && (a_sgn != b_sgn)))
         result = FP_QNAN;
      else if (a_inf)
         result = {a_sgn, 8'hFF, 23'd0};
      else if (b_inf)
         result = {b_sgn, 8'hFF, 23'd0};
   end

   // Delay the result through LAT ce-enabled stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= FP_ZERO;
      end else if (ce) begin
         pipe[0] <= result;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign y = pipe[LAT-1];

endmodule

// File: rtl/fp_addsub_hold_array.sv
// LANES-wide float add/sub stage with per-lane held results. Top level owns
// the run/accumulate FSM, the accumulate wait counter and the operand-B mux.
// Handshake: a beat transfers on a cycle where in_valid & in_ready are both
// high; in_ready already includes ce, so no beat is taken while ce is low.
module fp_addsub_hold_array
   import fp_addsub_hold_array_pkg::*;
#(
   parameter int WIDTH     = FP_WIDTH,
   parameter int LANES     = 4,
   parameter int FPADD_LAT = FPADD_LAT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ce,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   mode,
   input  logic                   op,
   input  logic [LANES-1:0]       lane_en,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic [LANES-1:0]       res_valid,
   output logic [LANES*WIDTH-1:0] held_out,
   output logic                   busy
);

   localparam int CW = (FPADD_LAT > 1) ? $clog2(FPADD_LAT) : 1;

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic                   mode_q;
   logic                   accept;
   logic                   flush;
   logic                   idle;
   logic [LANES-1:0]       lane_busy;
   logic [LANES*WIDTH-1:0] b_mux;

   assign busy   = |lane_busy;
   assign idle   = (state == ST_IDLE);
   assign flush  = ce & ~start;
   assign accept = in_valid & in_ready;

   // Ready only while running; a switch from streaming to accumulate waits
   // for the pipe to drain so the fed-back held value is final
   always_comb begin
      in_ready = ce && (state == ST_RUN) && !(mode && !mode_q && busy);
   end

   // Control FSM; start low overrides everything and returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mode_q <= 1'b0;
      end else if (ce) begin
         if (!start) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: state <= ST_RUN;
               ST_RUN: begin
                  if (accept) begin
                     mode_q <= mode;
                     if (mode) begin
                        state <= ST_ACC_WAIT;
                        cnt   <= CW'(FPADD_LAT - 1);
                     end
                  end
               end
               ST_ACC_WAIT: begin
                  // cnt reaches 0 in the cycle the result emerges
                  if (cnt == '0) state <= ST_RUN;
                  else           cnt   <= cnt - CW'(1);
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign b_mux[l*WIDTH +: WIDTH] = mode ? held_out[l*WIDTH +: WIDTH]
                                            : b[l*WIDTH +: WIDTH];

      fp_lane_hold #(.WIDTH(WIDTH), .FPADD_LAT(FPADD_LAT)) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .ce        (ce),
         .flush     (flush),
         .idle      (idle),
         .vin       (lane_en[l] & accept),
         .op        (op),
         .a         (a[l*WIDTH +: WIDTH]),
         .b         (b_mux[l*WIDTH +: WIDTH]),
         .res_valid (res_valid[l]),
         .held_out  (held_out[l*WIDTH +: WIDTH]),
         .busy      (lane_busy[l])
      );
   end

endmodule

// File: tb/tb_fp_addsub_hold_array.sv
// Bench for fp_addsub_hold_array: scenario tasks with randomized integer-valued
// floats, expected results computed with integer arithmetic then encoded.
module tb_fp_addsub_hold_array;

   localparam int W = 32;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           ce, start, in_valid, mode, op;
   logic           in_ready, busy;
   logic [L-1:0]   lane_en, res_valid;
   logic [L*W-1:0] a, b, held_out;
   logic [L*W-1:0] held_m;

   int vectors = 0;
   int errors  = 0;

   fp_addsub_hold_array dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ce        (ce),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .op        (op),
      .lane_en   (lane_en),
      .a         (a),
      .b         (b),
      .res_valid (res_valid),
      .held_out  (held_out),
      .busy      (busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // integer (|v| < 2^24) to single-precision bits
   function automatic logic [31:0] to_fp(input int v);
      logic [31:0] mag;
      logic [31:0] frac;
      int msb;
      if (v == 0) return 32'h0;
      mag = (v < 0) ? 32'(-v) : 32'(v);
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      frac = (mag << (23 - msb)) & 32'h007F_FFFF;
      return {(v < 0), 8'(127 + msb), frac[22:0]};
   endfunction

   function automatic int rnd_val();
      return int'($urandom_range(2000, 0)) - 1000;
   endfunction

   function automatic int rnd_nz();
      int v;
      v = rnd_val();
      if (v == 0) v = 7;
      return v;
   endfunction

   function automatic logic [31:0] lane_of(input logic [L*W-1:0] v, input int l);
      return v[l*W +: W];
   endfunction

   task automatic test_reset();
      ce = 1; start = 0; in_valid = 0; mode = 0; op = 0; lane_en = '0; a = '0; b = '0;
      #2 rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (res_valid !== '0) begin errors++; $display("FAIL reset_res_valid: got %h want 0", res_valid); end
      vectors++; if (held_out !== '0) begin errors++; $display("FAIL reset_held_out: got %h want 0", held_out); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1;
      tick();
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b want 0", in_ready); end
      start = 1;
      tick();
      #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b want 1", in_ready); end
      held_m = '0;
   endtask

   task automatic test_single();
      mode = 0; op = 0; lane_en = 4'b0001; a = '0; b = '0;
      a[0 +: W] = 32'h3F80_0000; b[0 +: W] = 32'h4000_0000;
      in_valid = 1;
      tick();
      in_valid = 0;
      for (int k = 1; k <= 6; k++) begin
         vectors++; if (res_valid[0] !== (k == 4)) begin errors++; $display("FAIL single_valid_c%0d: got %b want %b", k, res_valid[0], (k == 4)); end
         if (k >= 4) begin
            vectors++; if (lane_of(held_out, 0) !== 32'h4040_0000) begin errors++; $display("FAIL single_held_c%0d: got %h want 40400000", k, lane_of(held_out, 0)); end
         end
         if (k < 6) tick();
      end
      held_m[0 +: W] = 32'h4040_0000;
      vectors++; if (held_out !== held_m) begin errors++; $display("FAIL single_other_lanes: got %h want %h", held_out, held_m); end
   endtask

   task automatic test_accumulate();
      int acc [L];
      int av;
      logic [L*W-1:0] exp_v;
      start = 0; tick(); tick();
      start = 1; tick();
      vectors++; if (held_out !== '0) begin errors++; $display("FAIL acc_cleared: got %h want 0", held_out); end
      mode = 1; op = 0; lane_en = 4'b0010; a = '0; b = '0;
      a[1*W +: W] = 32'h3F80_0000;
      for (int n = 1; n <= 4; n++) begin
         in_valid = 1; #1;
         vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc1_ready_b%0d: got %b want 1", n, in_ready); end
         tick();
         in_valid = 0;
         for (int k = 1; k <= 4; k++) begin
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL acc1_stall_b%0d_c%0d: got %b want 0", n, k, in_ready); end
            if (k == 4) begin
               vectors++; if (res_valid !== 4'b0010) begin errors++; $display("FAIL acc1_valid_b%0d: got %b want 0010", n, res_valid); end
               vectors++; if (lane_of(held_out, 1) !== to_fp(n)) begin errors++; $display("FAIL acc1_held_b%0d: got %h want %h", n, lane_of(held_out, 1), to_fp(n)); end
            end
            tick();
         end
      end
      vectors++; if (lane_of(held_out, 1) !== 32'h4080_0000) begin errors++; $display("FAIL acc1_final: got %h want 40800000", lane_of(held_out, 1)); end
      // randomized accumulate on every lane: result = A op held
      for (int l = 0; l < L; l++) acc[l] = (l == 1) ? 4 : 0;
      lane_en = '1;
      for (int n = 0; n < 3; n++) begin
         op = 1'($urandom_range(1, 0));
         for (int l = 0; l < L; l++) begin
            av = rnd_val();
            a[l*W +: W] = to_fp(av);
            b[l*W +: W] = to_fp(rnd_val());
            acc[l] = op ? (av - acc[l]) : (av + acc[l]);
            exp_v[l*W +: W] = to_fp(acc[l]);
         end
         in_valid = 1; #1;
         vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accr_ready_b%0d: got %b want 1", n, in_ready); end
         tick();
         in_valid = 0;
         repeat (3) tick();
         vectors++; if (res_valid !== 4'b1111) begin errors++; $display("FAIL accr_valid_b%0d: got %b want 1111", n, res_valid); end
         vectors++; if (held_out !== exp_v) begin errors++; $display("FAIL accr_held_b%0d: got %h want %h", n, held_out, exp_v); end
         tick();
      end
      held_m = exp_v;
   endtask

   task automatic test_back_to_back();
      logic [L*W-1:0] exp_q[$];
      logic [L*W-1:0] exp_v, want;
      int av, bv;
      mode = 0; lane_en = '1;
      exp_v = held_m;
      for (int i = 1; i <= 13; i++) begin
         if (i <= 8) begin
            op = 1'($urandom_range(1, 0));
            for (int l = 0; l < L; l++) begin
               av = rnd_val(); bv = rnd_val();
               a[l*W +: W] = to_fp(av);
               b[l*W +: W] = to_fp(bv);
               exp_v[l*W +: W] = to_fp(op ? (av - bv) : (av + bv));
            end
            exp_q.push_back(exp_v);
            in_valid = 1; #1;
            vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d: got %b want 1", i, in_ready); end
         end else begin
            in_valid = 0;
         end
         tick();
         if (i >= 4 && i <= 11) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            vectors++; if (res_valid !== 4'b1111) begin errors++; $display("FAIL b2b_valid_c%0d: got %b want 1111", i, res_valid); end
            vectors++; if (held_out !== want) begin errors++; $display("FAIL b2b_held_c%0d: got %h want %h", i, held_out, want); end
         end else begin
            vectors++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL b2b_idle_valid_c%0d: got %b want 0000", i, res_valid); end
         end
      end
      held_m = exp_v;
   endtask

   task automatic test_mode_holdoff();
      int av, bv;
      logic [31:0] want;
      mode = 0; op = 0; lane_en = 4'b0001;
      av = rnd_val(); bv = rnd_val();
      a[0 +: W] = to_fp(av); b[0 +: W] = to_fp(bv);
      want = to_fp(av + bv);
      in_valid = 1;
      tick();
      in_valid = 0; mode = 1; #1;
      for (int k = 1; k <= 4; k++) begin
         vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_c%0d: got %b want 0", k, in_ready); end
         vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy_c%0d: got %b want 1", k, busy); end
         tick();
      end
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_drained: got %b want 1", in_ready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_drained: got %b want 0", busy); end
      vectors++; if (lane_of(held_out, 0) !== want) begin errors++; $display("FAIL hold_held: got %h want %h", lane_of(held_out, 0), want); end
      held_m[0 +: W] = want;
      mode = 0;
   endtask

   task automatic test_flush();
      mode = 0; op = 0; lane_en = '1;
      for (int l = 0; l < L; l++) begin
         a[l*W +: W] = to_fp(rnd_nz()); b[l*W +: W] = to_fp(rnd_val());
      end
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      start = 0;
      tick();
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
      vectors++; if (held_out !== held_m) begin errors++; $display("FAIL flush_held_kept: got %h want %h", held_out, held_m); end
      vectors++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid_c3: got %b want 0000", res_valid); end
      for (int k = 4; k <= 8; k++) begin
         tick();
         vectors++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid_c%0d: got %b want 0000", k, res_valid); end
         vectors++; if (held_out !== '0) begin errors++; $display("FAIL flush_cleared_c%0d: got %h want 0", k, held_out); end
         vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_c%0d: got %b want 0", k, in_ready); end
      end
      start = 1;
      tick();
      held_m = '0;
   endtask

   task automatic test_start_drop();
      int av, bv;
      logic [31:0] want;
      mode = 0; op = 1; lane_en = 4'b0100;
      av = rnd_nz(); bv = rnd_val();
      a[2*W +: W] = to_fp(av); b[2*W +: W] = to_fp(bv);
      want = to_fp(av - bv);
      in_valid = 1;
      tick();
      in_valid = 0;
      repeat (3) tick();
      vectors++; if (res_valid !== 4'b0100) begin errors++; $display("FAIL drop_valid: got %b want 0100", res_valid); end
      start = 0;
      tick();
      vectors++; if (lane_of(held_out, 2) !== want) begin errors++; $display("FAIL drop_captured: got %h want %h", lane_of(held_out, 2), want); end
      tick();
      vectors++; if (held_out !== '0) begin errors++; $display("FAIL drop_cleared: got %h want 0", held_out); end
      start = 1;
      tick();
      held_m = '0;
   endtask

   task automatic test_ce();
      int x, n;
      logic [31:0] want;
      x = rnd_nz();
      want = to_fp(x);
      mode = 1; op = 1'($urandom_range(1, 0)); lane_en = 4'b0001;
      a = '0; b = '0;
      a[0 +: W] = want;
      ce = 1; in_valid = 1; #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ce_accept_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n = 1;
      for (int it = 0; it < 40 && n < 7; it++) begin
         ce = (it == 0) ? 1'b0 : 1'($urandom_range(1, 0));
         #1;
         vectors++; if (in_ready !== (ce && n >= 5)) begin errors++; $display("FAIL ce_ready_i%0d: got %b want %b", it, in_ready, (ce && n >= 5)); end
         vectors++; if (res_valid !== ((n == 4) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL ce_valid_i%0d: got %b n=%0d", it, res_valid, n); end
         vectors++; if (lane_of(held_out, 0) !== ((n >= 4) ? want : 32'h0)) begin errors++; $display("FAIL ce_held_i%0d: got %h want %h", it, lane_of(held_out, 0), (n >= 4) ? want : 32'h0); end
         tick();
         if (ce) n++;
      end
      vectors++; if (n < 7) begin errors++; $display("FAIL ce_timeout: got %0d ce edges want 7", n); end
      ce = 1;
      held_m = '0;
      held_m[0 +: W] = want;
   endtask

   task automatic test_lane_mask();
      logic [L-1:0] mask;
      int av, bv;
      mode = 0; op = 1; lane_en = 4'b0101;
      for (int l = 0; l < L; l++) begin
         a[l*W +: W] = 32'h40C0_0000; b[l*W +: W] = 32'h4000_0000;
      end
      held_m[0*W +: W] = 32'h4080_0000;
      held_m[2*W +: W] = 32'h4080_0000;
      in_valid = 1; tick(); in_valid = 0;
      repeat (3) tick();
      vectors++; if (res_valid !== 4'b0101) begin errors++; $display("FAIL mask_valid: got %b want 0101", res_valid); end
      vectors++; if (held_out !== held_m) begin errors++; $display("FAIL mask_held: got %h want %h", held_out, held_m); end
      tick();
      vectors++; if (held_out !== held_m) begin errors++; $display("FAIL mask_held_after: got %h want %h", held_out, held_m); end
      for (int n = 0; n < 4; n++) begin
         mask = 4'($urandom_range(15, 0));
         op = 1'($urandom_range(1, 0));
         lane_en = mask;
         for (int l = 0; l < L; l++) begin
            av = rnd_val(); bv = rnd_val();
            a[l*W +: W] = to_fp(av); b[l*W +: W] = to_fp(bv);
            if (mask[l]) held_m[l*W +: W] = to_fp(op ? (av - bv) : (av + bv));
         end
         in_valid = 1; tick(); in_valid = 0;
         repeat (3) tick();
         vectors++; if (res_valid !== mask) begin errors++; $display("FAIL rmask_valid_b%0d: got %b want %b", n, res_valid, mask); end
         vectors++; if (held_out !== held_m) begin errors++; $display("FAIL rmask_held_b%0d: got %h want %h", n, held_out, held_m); end
         tick();
      end
      // all lanes disabled in accumulate mode: still accepted, still waits
      mode = 1; lane_en = '0; in_valid = 1; #1;
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      for (int k = 1; k <= 4; k++) begin
         vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_stall_c%0d: got %b want 0", k, in_ready); end
         vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy_c%0d: got %b want 0", k, busy); end
         tick();
      end
      vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL empty_resume: got %b want 1", in_ready); end
      vectors++; if (held_out !== held_m) begin errors++; $display("FAIL empty_held: got %h want %h", held_out, held_m); end
      mode = 0;
   endtask

   task automatic test_reset_mid();
      mode = 0; op = 0; lane_en = '1;
      for (int l = 0; l < L; l++) begin
         a[l*W +: W] = to_fp(rnd_nz()); b[l*W +: W] = to_fp(rnd_val());
      end
      in_valid = 1; tick(); in_valid = 0;
      tick();
      rst_n = 0;
      #1;
      vectors++; if (res_valid !== '0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", res_valid); end
      vectors++; if (held_out !== '0) begin errors++; $display("FAIL rstmid_held: got %h want 0", held_out); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_accumulate();
      test_back_to_back();
      test_mode_holdoff();
      test_flush();
      test_start_drop();
      test_ce();
      test_lane_mask();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
